// File: rtl/pe_row_conv.sv
// Row-stationary PE: loads a filter row, slides it over an ifmap row and emits psum_in + dot product per position.
// Build option: define PE_PSUM_SAT_EN to saturate the output psum instead of two's-complement wrapping.
module pe_row_conv #(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 32,
  parameter int FILTER_LEN = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [7:0]                   ifmap_len,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic signed [DATA_WIDTH-1:0] w_data,
  input  logic                         if_valid,
  output logic                         if_ready,
  input  logic signed [DATA_WIDTH-1:0] if_data,
  input  logic                         ps_in_valid,
  output logic                         ps_in_ready,
  input  logic signed [PSUM_WIDTH-1:0] ps_in_data,
  output logic                         ps_out_valid,
  input  logic                         ps_out_ready,
  output logic signed [PSUM_WIDTH-1:0] ps_out_data,
  output logic                         busy,
  output logic                         done
);

  localparam int ACC_W  = PSUM_WIDTH + 4;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int IDX_W  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TOP_W  = ACC_W - PSUM_WIDTH + 1;

`ifdef PE_PSUM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_FILL, S_WAIT_PS, S_MAC, S_OUT, S_SHIFT
  } state_t;

  state_t                        state_r, state_s;
  logic signed [DATA_WIDTH-1:0]  w_r [FILTER_LEN];
  logic signed [DATA_WIDTH-1:0]  x_r [FILTER_LEN];
  logic signed [ACC_W-1:0]       acc_r;
  logic [IDX_W-1:0]              idx_r;
  logic [7:0]                    num_out_r, out_cnt_r;

  logic                          start_ok_s, idx_last_s, last_out_s;
  logic                          w_fire_s, if_fire_s, ps_in_fire_s, ps_out_fire_s;
  logic signed [DATA_WIDTH-1:0]  w_sel_s, x_sel_s;
  logic signed [PROD_W-1:0]      prod_s;
  logic signed [ACC_W-1:0]       acc_sum_s;
  logic [IDX_W-1:0]              idx_next_s;

  // Narrow the accumulator to the psum width: pass through when it fits, otherwise clamp or wrap.
  function automatic logic signed [PSUM_WIDTH-1:0] to_psum(input logic signed [ACC_W-1:0] a);
    logic [TOP_W-1:0]             top;
    logic signed [PSUM_WIDTH-1:0] r;
    top = a[ACC_W-1:PSUM_WIDTH-1];
    if (!SAT_EN || (top == {TOP_W{1'b0}}) || (top == {TOP_W{1'b1}})) begin
      r = a[PSUM_WIDTH-1:0];
    end else if (a[ACC_W-1]) begin
      r = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
    end else begin
      r = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    end
    return r;
  endfunction

  // Handshakes, counters and the single shared multiplier
  always_comb begin
    start_ok_s    = start && (ifmap_len >= 8'(FILTER_LEN));
    w_fire_s      = w_valid && w_ready;
    if_fire_s     = if_valid && if_ready;
    ps_in_fire_s  = ps_in_valid && ps_in_ready;
    ps_out_fire_s = ps_out_valid && ps_out_ready;
    idx_last_s    = (idx_r == IDX_W'(FILTER_LEN - 1));
    idx_next_s    = idx_last_s ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1));
    last_out_s    = (out_cnt_r == (num_out_r - 8'd1));
    w_sel_s       = w_r[idx_r];
    x_sel_s       = x_r[idx_r];
    prod_s        = PROD_W'(w_sel_s) * PROD_W'(x_sel_s);
    acc_sum_s     = acc_r + ACC_W'(prod_s);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_ok_s) state_s = S_LOAD_W;
        else            state_s = S_IDLE;
      end
      S_LOAD_W: begin
        if (w_fire_s && idx_last_s) state_s = S_FILL;
        else                        state_s = S_LOAD_W;
      end
      S_FILL: begin
        if (if_fire_s && idx_last_s) state_s = S_WAIT_PS;
        else                         state_s = S_FILL;
      end
      S_WAIT_PS: begin
        if (ps_in_fire_s) state_s = S_MAC;
        else              state_s = S_WAIT_PS;
      end
      S_MAC: begin
        if (idx_last_s) state_s = S_OUT;
        else            state_s = S_MAC;
      end
      S_OUT: begin
        if (ps_out_fire_s && last_out_s)  state_s = S_IDLE;
        else if (ps_out_fire_s)           state_s = S_SHIFT;
        else                              state_s = S_OUT;
      end
      S_SHIFT: begin
        if (if_fire_s) state_s = S_WAIT_PS;
        else           state_s = S_SHIFT;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register, registered handshake outputs and datapath updates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      w_ready      <= 1'b0;
      if_ready     <= 1'b0;
      ps_in_ready  <= 1'b0;
      ps_out_valid <= 1'b0;
      ps_out_data  <= {PSUM_WIDTH{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      acc_r        <= {ACC_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      num_out_r    <= 8'd0;
      out_cnt_r    <= 8'd0;
      for (int j = 0; j < FILTER_LEN; j++) begin
        w_r[j] <= {DATA_WIDTH{1'b0}};
        x_r[j] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_r      <= state_s;
      // Readies follow the next state so each is high exactly while its state is current.
      w_ready      <= (state_s == S_LOAD_W);
      if_ready     <= (state_s == S_FILL) || (state_s == S_SHIFT);
      ps_in_ready  <= (state_s == S_WAIT_PS);
      ps_out_valid <= (state_s == S_OUT);
      busy         <= (state_s != S_IDLE);
      done         <= (state_r == S_OUT) && ps_out_fire_s && last_out_s;
      case (state_r)
        S_IDLE: begin
          if (start_ok_s) begin
            num_out_r <= ifmap_len - 8'(FILTER_LEN) + 8'd1;
            out_cnt_r <= 8'd0;
            idx_r     <= {IDX_W{1'b0}};
          end
        end
        S_LOAD_W: begin
          if (w_fire_s) begin
            w_r[idx_r] <= w_data;
            idx_r      <= idx_next_s;
          end
        end
        S_FILL, S_SHIFT: begin
          if (if_fire_s) begin
            for (int j = 0; j < FILTER_LEN - 1; j++) x_r[j] <= x_r[j+1];
            x_r[FILTER_LEN-1] <= if_data;
            if (state_r == S_FILL) idx_r <= idx_next_s;
          end
        end
        S_WAIT_PS: begin
          if (ps_in_fire_s) begin
            acc_r <= ACC_W'(ps_in_data);
            idx_r <= {IDX_W{1'b0}};
          end
        end
        S_MAC: begin
          acc_r <= acc_sum_s;
          idx_r <= idx_next_s;
          if (idx_last_s) ps_out_data <= to_psum(acc_sum_s);
        end
        S_OUT: begin
          if (ps_out_fire_s && !last_out_s) out_cnt_r <= out_cnt_r + 8'd1;
        end
        default: begin
          idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

endmodule
